// File: rtl/bp_be_pkg.sv
// Shared back-end definitions for the calculator dependency-status interface.
//
// Contents:
//   reg_addr_width_gp   - architectural register index width
//   dep_*_gp            - stage index of each tracked pipeline stage in the
//                         dep_status vector (stage 0 sits at the LSB)
//   bp_be_dep_status_s  - one tracked stage: valid, serializing/memory flags,
//                         destination register and write-back source classes
package bp_be_pkg;

    localparam int reg_addr_width_gp = 5;

    localparam int dep_ex1_gp  = 0;
    localparam int dep_ex2_gp  = 1;
    localparam int dep_iwb_gp  = 2;  // ex3 / integer write-back
    localparam int dep_fwb0_gp = 3;
    localparam int dep_fwb1_gp = 4;

    typedef struct packed {
        logic                         v;
        logic                         serial_v;
        logic                         mem_v;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic                         mul_iwb_v;
        logic                         mem_iwb_v;
        logic                         fp_iwb_v;
        logic                         mem_fwb_v;
        logic                         fp_fwb_v;
    } bp_be_dep_status_s;

endpackage

// File: rtl/bp_be_credit_tracker.sv
// Up/down counter of outstanding memory transactions.
//
// Ports:
//   clk_i, reset_i  - clock, asynchronous active-high reset
//   inc_i           - a memory transaction was issued
//   dec_i           - a memory credit came back
//   full_o          - count == credits_p (decoded from the registered count)
//   empty_o         - count == 0        (decoded from the registered count)
//
// Illegal overflow/underflow events raise a warning and leave the count held.
module bp_be_credit_tracker
    import bp_be_pkg::*;
#(
    parameter int credits_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int credit_width_p = $clog2(credits_p + 1);

    logic [credit_width_p-1:0] count_q, count_d;

    assign full_o  = (count_q == credit_width_p'(credits_p));
    assign empty_o = (count_q == '0);

    // Simultaneous inc/dec cancel; illegal moves past either bound hold.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && !empty_o) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(inc_i && !dec_i && full_o))
                else $warning("credit overflow: inc while all credits outstanding");
            assert (!(dec_i && !inc_i && empty_o))
                else $warning("credit underflow: dec with no credits outstanding");
        end
    end

endmodule

// File: rtl/bp_be_dep_tracker.sv
// Producer side of the calculator dependency-status interface.
//
// Records every dispatch into the calculator pipe, shifts the records one
// stage per cycle (never stalls), applies ex1/ex2 squashes, and publishes the
// registered per-stage status for the hazard checker together with the
// memory-credit full/empty flags.
//
// Ports:
//   clk_i, reset_i       - clock, asynchronous active-high reset
//   dispatch_v_i         - instruction enters ex1 this cycle
//   disp_*_i             - destination register and flags of that instruction
//   kill_isd_i           - drop the dispatch presented this cycle
//   kill_ex1_i/ex2_i     - squash stage 0 / stage 1 contents as they advance
//   credit_inc_i/dec_i   - memory transaction issued / credit returned
//   dep_status_o         - dep_stages_p packed entries, stage 0 at the LSB
//   credits_full_o/empty_o - outstanding-credit count at limit / at zero
module bp_be_dep_tracker
    import bp_be_pkg::*;
#(
    parameter int reg_addr_width_p = 5,
    parameter int dep_stages_p     = 5,
    parameter int credits_p        = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        dispatch_v_i,
    input  logic [reg_addr_width_p-1:0] disp_rd_addr_i,
    input  logic                        disp_mul_iwb_i,
    input  logic                        disp_mem_iwb_i,
    input  logic                        disp_fp_iwb_i,
    input  logic                        disp_mem_fwb_i,
    input  logic                        disp_fp_fwb_i,
    input  logic                        disp_serial_i,
    input  logic                        disp_mem_i,
    input  logic                        kill_isd_i,
    input  logic                        kill_ex1_i,
    input  logic                        kill_ex2_i,
    input  logic                        credit_inc_i,
    input  logic                        credit_dec_i,
    output logic [dep_stages_p*$bits(bp_be_dep_status_s)-1:0] dep_status_o,
    output logic                        credits_full_o,
    output logic                        credits_empty_o
);

    bp_be_dep_status_s [dep_stages_p-1:0] stage_q, stage_d;

    // A squashed or absent slot is carried as an all-zero entry so the
    // checker never sees a stale rd_addr alongside a cleared valid.
    always_comb begin
        stage_d = '0;
        if (dispatch_v_i && !kill_isd_i) begin
            stage_d[0].v         = 1'b1;
            stage_d[0].serial_v  = disp_serial_i;
            stage_d[0].mem_v     = disp_mem_i;
            stage_d[0].rd_addr   = disp_rd_addr_i;
            stage_d[0].mul_iwb_v = disp_mul_iwb_i;
            stage_d[0].mem_iwb_v = disp_mem_iwb_i;
            stage_d[0].fp_iwb_v  = disp_fp_iwb_i;
            stage_d[0].mem_fwb_v = disp_mem_fwb_i;
            stage_d[0].fp_fwb_v  = disp_fp_fwb_i;
        end
        for (int k = 1; k < dep_stages_p; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        if (kill_ex1_i) begin
            stage_d[dep_ex2_gp] = '0;
        end
        if (kill_ex2_i) begin
            stage_d[dep_iwb_gp] = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dep_status_o = stage_q;

    bp_be_credit_tracker #(
        .credits_p(credits_p)
    ) credits (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc_i  (credit_inc_i),
        .dec_i  (credit_dec_i),
        .full_o (credits_full_o),
        .empty_o(credits_empty_o)
    );

endmodule

// File: tb/tb_bp_be_dep_tracker.sv
// Directed bench for bp_be_dep_tracker.
module tb_bp_be_dep_tracker;
    import bp_be_pkg::*;

    localparam int SW = $bits(bp_be_dep_status_s);
    localparam int NS = 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          dispatch_v_i;
    logic [4:0]    disp_rd_addr_i;
    logic          disp_mul_iwb_i, disp_mem_iwb_i, disp_fp_iwb_i;
    logic          disp_mem_fwb_i, disp_fp_fwb_i;
    logic          disp_serial_i, disp_mem_i;
    logic          kill_isd_i, kill_ex1_i, kill_ex2_i;
    logic          credit_inc_i, credit_dec_i;
    logic [NS*SW-1:0] dep_status_o;
    logic          credits_full_o, credits_empty_o;

    int vecs = 0;
    int errs = 0;

    bp_be_dep_tracker dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .dispatch_v_i   (dispatch_v_i),
        .disp_rd_addr_i (disp_rd_addr_i),
        .disp_mul_iwb_i (disp_mul_iwb_i),
        .disp_mem_iwb_i (disp_mem_iwb_i),
        .disp_fp_iwb_i  (disp_fp_iwb_i),
        .disp_mem_fwb_i (disp_mem_fwb_i),
        .disp_fp_fwb_i  (disp_fp_fwb_i),
        .disp_serial_i  (disp_serial_i),
        .disp_mem_i     (disp_mem_i),
        .kill_isd_i     (kill_isd_i),
        .kill_ex1_i     (kill_ex1_i),
        .kill_ex2_i     (kill_ex2_i),
        .credit_inc_i   (credit_inc_i),
        .credit_dec_i   (credit_dec_i),
        .dep_status_o   (dep_status_o),
        .credits_full_o (credits_full_o),
        .credits_empty_o(credits_empty_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bp_be_dep_status_s stg(input int k);
        return dep_status_o[k*SW +: SW];
    endfunction

    task automatic idle_inputs();
        dispatch_v_i   = 1'b0;
        disp_rd_addr_i = '0;
        disp_mul_iwb_i = 1'b0;
        disp_mem_iwb_i = 1'b0;
        disp_fp_iwb_i  = 1'b0;
        disp_mem_fwb_i = 1'b0;
        disp_fp_fwb_i  = 1'b0;
        disp_serial_i  = 1'b0;
        disp_mem_i     = 1'b0;
        kill_isd_i     = 1'b0;
        kill_ex1_i     = 1'b0;
        kill_ex2_i     = 1'b0;
        credit_inc_i   = 1'b0;
        credit_dec_i   = 1'b0;
    endtask

    task automatic flush();
        idle_inputs();
        repeat (NS + 1) @(negedge clk_i);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        vecs++;
        if (dep_status_o !== '0)
            $display("FAIL reset_status: got %h expected 0", dep_status_o);
        if (dep_status_o !== '0) errs++;
        vecs++;
        if (credits_empty_o !== 1'b1 || credits_full_o !== 1'b0) begin
            $display("FAIL reset_credits: got empty=%b full=%b expected empty=1 full=0",
                     credits_empty_o, credits_full_o);
            errs++;
        end
    endtask

    task automatic test_single_dispatch();
        bp_be_dep_status_s exp;
        logic [NS*SW-1:0]  expv;
        exp = '0;
        exp.v = 1'b1;
        exp.rd_addr = 5'd7;
        exp.mem_iwb_v = 1'b1;
        dispatch_v_i   = 1'b1;
        disp_rd_addr_i = 5'd7;
        disp_mem_iwb_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        for (int c = 1; c <= NS + 1; c++) begin
            expv = '0;
            if (c <= NS) expv[(c-1)*SW +: SW] = exp;
            vecs++;
            if (dep_status_o !== expv) begin
                $display("FAIL single_cycle%0d: got %h expected %h", c, dep_status_o, expv);
                errs++;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= NS; i++) begin
            dispatch_v_i   = 1'b1;
            disp_rd_addr_i = 5'(i);
            @(negedge clk_i);
        end
        idle_inputs();
        for (int k = 0; k < NS; k++) begin
            vecs++;
            if (stg(k).v !== 1'b1 || stg(k).rd_addr !== 5'(NS - k)) begin
                $display("FAIL b2b_stage%0d: got v=%b rd=%0d expected v=1 rd=%0d",
                         k, stg(k).v, stg(k).rd_addr, NS - k);
                errs++;
            end
        end
        flush();
    endtask

    task automatic test_squash();
        bp_be_dep_status_s exp0;
        // both kills together with a live dispatch
        dispatch_v_i = 1'b1; disp_rd_addr_i = 5'd8; disp_fp_fwb_i = 1'b1;
        @(negedge clk_i);
        disp_rd_addr_i = 5'd9; disp_fp_fwb_i = 1'b0; disp_mul_iwb_i = 1'b1;
        @(negedge clk_i);
        disp_rd_addr_i = 5'd10; disp_mul_iwb_i = 1'b0;
        kill_ex1_i = 1'b1; kill_ex2_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        exp0 = '0; exp0.v = 1'b1; exp0.rd_addr = 5'd10;
        vecs++;
        if (stg(0) !== exp0) begin
            $display("FAIL squash_stage0: got %h expected %h", stg(0), exp0);
            errs++;
        end
        vecs++;
        if (stg(1) !== '0 || stg(2) !== '0) begin
            $display("FAIL squash_both: got s1=%h s2=%h expected 0 0", stg(1), stg(2));
            errs++;
        end
        flush();
        // kill_ex1 alone: only stage 1 is cleared, stage 2 advances normally
        dispatch_v_i = 1'b1; disp_rd_addr_i = 5'd11;
        @(negedge clk_i);
        disp_rd_addr_i = 5'd12;
        @(negedge clk_i);
        dispatch_v_i = 1'b0; kill_ex1_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        vecs++;
        if (stg(1) !== '0 || stg(2).v !== 1'b1 || stg(2).rd_addr !== 5'd11) begin
            $display("FAIL squash_ex1_only: got s1=%h s2.v=%b s2.rd=%0d expected 0 1 11",
                     stg(1), stg(2).v, stg(2).rd_addr);
            errs++;
        end
        flush();
        // kill_ex2 alone: stage 2 cleared, stage 1 advances normally
        dispatch_v_i = 1'b1; disp_rd_addr_i = 5'd14;
        @(negedge clk_i);
        disp_rd_addr_i = 5'd15;
        @(negedge clk_i);
        dispatch_v_i = 1'b0; kill_ex2_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        vecs++;
        if (stg(2) !== '0 || stg(1).v !== 1'b1 || stg(1).rd_addr !== 5'd15) begin
            $display("FAIL squash_ex2_only: got s2=%h s1.v=%b s1.rd=%0d expected 0 1 15",
                     stg(2), stg(1).v, stg(1).rd_addr);
            errs++;
        end
        flush();
    endtask

    task automatic test_kill_isd();
        dispatch_v_i = 1'b1; disp_rd_addr_i = 5'd13; disp_serial_i = 1'b1;
        kill_isd_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        vecs++;
        if (stg(0) !== '0) begin
            $display("FAIL kill_isd: got %h expected 0", stg(0));
            errs++;
        end
        flush();
    endtask

    task automatic test_credits();
        for (int i = 1; i <= 4; i++) begin
            credit_inc_i = 1'b1;
            @(negedge clk_i);
            vecs++;
            if (credits_full_o !== (i == 4) || credits_empty_o !== 1'b0) begin
                $display("FAIL credit_inc%0d: got full=%b empty=%b expected full=%b empty=0",
                         i, credits_full_o, credits_empty_o, (i == 4));
                errs++;
            end
        end
        credit_dec_i = 1'b1;
        @(negedge clk_i);
        vecs++;
        if (credits_full_o !== 1'b1) begin
            $display("FAIL credit_inc_dec_hold: got full=%b expected 1", credits_full_o);
            errs++;
        end
        credit_dec_i = 1'b0;
        @(negedge clk_i);   // overflow attempt, count must stay 4
        credit_inc_i = 1'b0;
        vecs++;
        if (credits_full_o !== 1'b1) begin
            $display("FAIL credit_overflow_hold: got full=%b expected 1", credits_full_o);
            errs++;
        end
        for (int i = 1; i <= 4; i++) begin
            credit_dec_i = 1'b1;
            @(negedge clk_i);
            vecs++;
            if (credits_empty_o !== (i == 4) || credits_full_o !== 1'b0) begin
                $display("FAIL credit_dec%0d: got empty=%b full=%b expected empty=%b full=0",
                         i, credits_empty_o, credits_full_o, (i == 4));
                errs++;
            end
        end
        @(negedge clk_i);   // underflow attempt, count must stay 0
        credit_dec_i = 1'b0;
        vecs++;
        if (credits_empty_o !== 1'b1) begin
            $display("FAIL credit_underflow_hold: got empty=%b expected 1", credits_empty_o);
            errs++;
        end
        credit_inc_i = 1'b1;
        @(negedge clk_i);
        credit_inc_i = 1'b0;
        vecs++;
        if (credits_empty_o !== 1'b0 || credits_full_o !== 1'b0) begin
            $display("FAIL credit_after_underflow: got empty=%b full=%b expected 0 0",
                     credits_empty_o, credits_full_o);
            errs++;
        end
        credit_dec_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_serial_mem();
        dispatch_v_i = 1'b1; disp_rd_addr_i = 5'd3;
        disp_serial_i = 1'b1; disp_mem_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        for (int c = 1; c <= NS; c++) begin
            vecs++;
            if (stg(c-1).v !== 1'b1 || stg(c-1).serial_v !== 1'b1 || stg(c-1).mem_v !== 1'b1) begin
                $display("FAIL serial_mem_stage%0d: got v=%b serial=%b mem=%b expected 1 1 1",
                         c - 1, stg(c-1).v, stg(c-1).serial_v, stg(c-1).mem_v);
                errs++;
            end
            @(negedge clk_i);
        end
        vecs++;
        if (dep_status_o !== '0) begin
            $display("FAIL serial_mem_clear: got %h expected 0", dep_status_o);
            errs++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 3; i++) begin
            dispatch_v_i = 1'b1; disp_rd_addr_i = 5'(i);
            credit_inc_i = (i <= 2);
            @(negedge clk_i);
        end
        idle_inputs();
        vecs++;
        if (stg(0).v !== 1'b1 || stg(2).v !== 1'b1 || credits_empty_o !== 1'b0) begin
            $display("FAIL async_reset_setup: got s0.v=%b s2.v=%b empty=%b expected 1 1 0",
                     stg(0).v, stg(2).v, credits_empty_o);
            errs++;
        end
        #2;
        reset_i = 1'b1;
        #1;
        vecs++;
        if (dep_status_o !== '0 || credits_empty_o !== 1'b1 || credits_full_o !== 1'b0) begin
            $display("FAIL async_reset: got status=%h empty=%b full=%b expected 0 1 0",
                     dep_status_o, credits_empty_o, credits_full_o);
            errs++;
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        vecs++;
        if (dep_status_o !== '0 || credits_empty_o !== 1'b1) begin
            $display("FAIL post_reset: got status=%h empty=%b expected 0 1",
                     dep_status_o, credits_empty_o);
            errs++;
        end
    endtask

    initial begin
        test_reset();
        test_single_dispatch();
        test_back_to_back();
        test_squash();
        test_kill_isd();
        test_credits();
        test_serial_mem();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bp_be_dep_tracker.md
Name: bp_be_dep_tracker

Overview:
Producer side of the calculator dependency-status interface.
- Records every instruction dispatched into the BE calculator pipe.
- Advances the records one stage per cycle and applies squash/poison.
- Publishes a 5-entry dep_status vector (ex1, ex2, ex3/iwb, fwb0, fwb1) for the hazard checker.
- Tracks outstanding memory credits and drives credits_full/credits_empty to the checker.

Parameters:
- reg_addr_width_p, 5, architectural register index width.
- dep_stages_p, 5, tracked pipeline stages; fixed at 5 for this revision.
- credits_p, 4, maximum outstanding memory transactions (≥1).
- credit_width_p, `BSG_WIDTH(credits_p)`, credit counter width (derived, localparam).

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  asynchronous, active-high reset
- dispatch_v_i  in  1  instruction dispatched into ex1 this cycle
- disp_rd_addr_i  in  reg_addr_width_p  destination register
- disp_mul_iwb_i / disp_mem_iwb_i / disp_fp_iwb_i  in  1 each  integer write-back source class
- disp_mem_fwb_i / disp_fp_fwb_i  in  1 each  FP write-back source class
- disp_serial_i  in  1  serializing instruction
- disp_mem_i  in  1  memory instruction
- kill_isd_i  in  1  squash the dispatch presented this cycle
- kill_ex1_i  in  1  squash contents of stage 0 before advance
- kill_ex2_i  in  1  squash contents of stage 1 before advance
- credit_inc_i  in  1  memory transaction issued to memory system
- credit_dec_i  in  1  memory credit returned
- dep_status_o  out  dep_stages_p*$bits(bp_be_dep_status_s)  packed, stage 0 at LSB
- credits_full_o  out  1  count == credits_p
- credits_empty_o  out  1  count == 0

Behaviour:
- Entry fields: v, serial_v, mem_v, rd_addr, mul_iwb_v, mem_iwb_v, fp_iwb_v, mem_fwb_v, fp_fwb_v.
- Reset (async, active-high): every field of every stage is 0, count = 0.
  - Outputs during and after reset: dep_status_o = 0, credits_empty_o = 1, credits_full_o = 0.
  - Reset asserted mid-operation discards all entries and credits immediately, without waiting for a clock edge.
- Stage 0 next value:
  - If dispatch_v_i & ~kill_isd_i, load the disp_* fields with v = 1.
  - Otherwise load an all-zero entry (rd_addr = 0).
- Stage k next value (k = 1..4): stage k-1 current value, except:
  - When kill_ex1_i is set, stage 1 receives all-zero.
  - When kill_ex2_i is set, stage 2 receives all-zero.
- Squash zeroes v, serial_v, mem_v and every *_wb_v flag. rd_addr is don't-care but is driven to 0.
- The pipe never stalls: entries leave stage 4 unconditionally.
- Latency: dispatch at cycle N is visible in dep_status_o[0] at cycle N+1 and in dep_status_o[4] at cycle N+5.
- Outputs are registered only, with no combinational input→output path. dep_status_o changes only on clk_i edges or reset.
- Write-back flags are carried unmodified through all stages; per-stage masking is the checker's job.
- The tracker does not decode instructions. It does not suppress x0; the checker filters rd_addr == 0.
- Simultaneous kill_ex1_i and kill_ex2_i squash both stages. Either may coincide with a valid dispatch, which is still recorded unless kill_isd_i is set.
- Credit counter:
  - inc & ~dec → count + 1.
  - dec & ~inc → count − 1.
  - Both or neither → count holds.
  - inc at count == credits_p (no simultaneous dec) is illegal: assertion fires, count holds.
  - dec at count == 0 (no simultaneous inc) is illegal: assertion fires, count holds.
  - credits_full_o and credits_empty_o are decoded from the registered count.

Decomposition:
- bp_be_pkg: bp_be_dep_status_s (shared with the checker) and the stage index constants (ex1 = 0 … fwb1 = 4).
- Sub-module bp_be_credit_tracker: the up/down credit counter, its full/empty decode and the illegal-event assertions.
- The stage shift register stays inline.

Test Plan:
- Reset: assert reset_i asynchronously mid-cycle with 3 valid entries and count = 2 → dep_status_o = 0, empty = 1, full = 0 before the next edge.
- Single dispatch: rd_addr = 7, disp_mem_iwb_i = 1 at cycle 0 → stage0.v = 1, rd_addr = 7, mem_iwb_v = 1 at cycle 1; reaches stage 4 at cycle 5; all zero at cycle 6.
- Back-to-back dispatch: rd = 1, 2, 3, 4, 5 on consecutive cycles → at cycle 5, stages 0..4 hold rd = 5, 4, 3, 2, 1, all v = 1.
- Squash:
  - Preload stages 0/1 with rd = 9/8, assert kill_ex1_i and kill_ex2_i with a dispatch of rd = 10 → next cycle stage0 rd = 10 v = 1, stages 1 and 2 v = 0 with all flags 0.
  - kill_isd_i with dispatch_v_i → stage0 v = 0.
- Credits:
  - 4 inc pulses → full = 1 after the 4th.
  - inc + dec together → count holds at 4.
  - 4 dec pulses → empty = 1.
  - 5th inc while full → assertion fires, count stays 4.
- Serial/mem flags: dispatch disp_serial_i = 1, disp_mem_i = 1 → serial_v and mem_v stay set in each stage for 5 consecutive cycles, then clear.
